fwrisc_fetch_pf: RTL and testbench



---
 rtl/fwrisc_fetch_pkg.sv | 14 +
 rtl/fwrisc_fifo.sv | 83 ++++++++
 rtl/fwrisc_fetch_pf.sv | 97 +++++++++
 tb/tb_fwrisc_fetch_pf.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fwrisc_fetch_pkg.sv
// Shared types for the fwrisc prefetching fetch unit.
// Optional same-cycle bypass is enabled with FWRISC_FETCH_BYPASS_EN.
package fwrisc_fetch_pkg;

    localparam logic [31:0] FETCH_RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [31:2] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fwrisc_fifo.sv
// Synchronous circular FIFO with flush, used as the prefetch buffer.
// Flush and reset return both pointers to entry 0.
module fwrisc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; entries are only visible once counted.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fwrisc_fetch_pf.sv
// Prefetching instruction fetch unit with redirect/flush support.
// Define FWRISC_FETCH_BYPASS_EN for a zero-latency empty-buffer path.
module fwrisc_fetch_pf
    import fwrisc_fetch_pkg::*;
#(
    parameter int          DEPTH        = 2,
    parameter logic [31:0] RESET_VECTOR = FETCH_RESET_VECTOR
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] iaddr,
    input  logic [31:0] idata,
    output logic        ivalid,
    input  logic        iready,
    input  logic        redir_valid,
    input  logic [31:0] redir_addr,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:2]  fpc_q, fpc_d;
    logic [CW-1:0] fifo_count;
    logic         fifo_empty;
    logic         fetch_xfer;
    logic         bypass;
    logic         push;
    logic         pop;
    fetch_entry_t wr_entry;
    fetch_entry_t rd_entry;

    assign ivalid     = !reset && !redir_valid && (fifo_count < CW'(DEPTH));
    assign iaddr      = {fpc_q, 2'b00};
    assign fetch_xfer = ivalid && iready;

`ifdef FWRISC_FETCH_BYPASS_EN
    assign bypass = fifo_empty && fetch_xfer;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word that decode takes immediately never enters the buffer.
    assign push     = fetch_xfer && !(bypass && instr_ready);
    assign pop      = !fifo_empty && instr_ready;
    assign wr_entry = '{pc: fpc_q, instr: idata};

    fwrisc_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (redir_valid),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    always_comb begin
        instr       = '0;
        instr_pc    = '0;
        instr_valid = 1'b0;
        if (!fifo_empty) begin
            instr       = rd_entry.instr;
            instr_pc    = {rd_entry.pc, 2'b00};
            instr_valid = 1'b1;
        end else if (bypass) begin
            instr       = idata;
            instr_pc    = iaddr;
            instr_valid = 1'b1;
        end
    end

    always_comb begin
        fpc_d = fpc_q;
        if (redir_valid) begin
            fpc_d = redir_addr[31:2];
        end else if (fetch_xfer) begin
            fpc_d = fpc_q + 30'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fpc_q <= RESET_VECTOR[31:2];
        end else begin
            fpc_q <= fpc_d;
        end
    end

endmodule

// File: tb/tb_fwrisc_fetch_pf.sv
// Scoreboard bench for fwrisc_fetch_pf against an in-order fetch model.
// Honours FWRISC_FETCH_BYPASS_EN when the design is built with it.
module tb_fwrisc_fetch_pf;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RV    = 32'h0000_0100;

    logic        clock;
    logic        reset;
    logic [31:0] iaddr;
    logic [31:0] idata;
    logic        ivalid;
    logic        iready;
    logic        redir_valid;
    logic [31:0] redir_addr;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    fwrisc_fetch_pf #(
        .DEPTH        (DEPTH),
        .RESET_VECTOR (RV)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .iaddr       (iaddr),
        .idata       (idata),
        .ivalid      (ivalid),
        .iready      (iready),
        .redir_valid (redir_valid),
        .redir_addr  (redir_addr),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] bus_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    // Memory model: the bus returns a word derived from the address.
    assign idata = bus_word(iaddr);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] w;
    } exp_t;

    exp_t        q[$];
    logic [31:0] exp_pc = RV;
    int          errors = 0;
    int          checks = 0;
    int          popped;
    bit          bypass_taken;
    bit          byp;
    bit          rst_prev = 1'b0;
    bit          exp_iv;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Decode-side monitor: pops the scoreboard on each consumed instruction.
    always @(negedge clock) begin
        popped       = 0;
        bypass_taken = 1'b0;
        byp          = 1'b0;
        if (reset) begin
            if (rst_prev) begin
                chk("reset_instr_valid", 32'(instr_valid), 32'd0);
                chk("reset_instr", instr, 32'd0);
            end
        end else if (q.size() != 0) begin
            chk("instr_valid", 32'(instr_valid), 32'd1);
            chk("instr_pc", instr_pc, q[0].pc);
            chk("instr", instr, q[0].w);
            if (instr_ready) begin
                void'(q.pop_front());
                popped = 1;
            end
        end else begin
`ifdef FWRISC_FETCH_BYPASS_EN
            byp = !redir_valid && iready;
`endif
            if (byp) begin
                chk("bypass_valid", 32'(instr_valid), 32'd1);
                chk("bypass_pc", instr_pc, exp_pc);
                chk("bypass_instr", instr, bus_word(exp_pc));
                bypass_taken = instr_ready;
            end else begin
                chk("empty_valid", 32'(instr_valid), 32'd0);
                chk("empty_instr", instr, 32'd0);
                chk("empty_pc", instr_pc, 32'd0);
            end
        end
        rst_prev = reset;
    end

    // Bus-side model: issues expected entries on each accepted fetch.
    always @(negedge clock) begin
        #1;
        if (reset) begin
            chk("reset_ivalid", 32'(ivalid), 32'd0);
            q.delete();
            exp_pc = RV;
        end else begin
            exp_iv = !redir_valid && ((q.size() + popped) < DEPTH);
            chk("ivalid", 32'(ivalid), 32'(exp_iv));
            if (exp_iv) chk("iaddr", iaddr, exp_pc);
            if (redir_valid) begin
                q.delete();
                exp_pc = {redir_addr[31:2], 2'b00};
            end else if (exp_iv && iready) begin
                if (!bypass_taken) q.push_back('{exp_pc, bus_word(exp_pc)});
                exp_pc = exp_pc + 32'd4;
            end
        end
    end

    task automatic step(input bit ir, input bit dr, input bit rv,
                        input logic [31:0] ra);
        iready      = ir;
        instr_ready = dr;
        redir_valid = rv;
        redir_addr  = ra;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        iready      = 1'b1;
        instr_ready = 1'b0;
        redir_valid = 1'b0;
        redir_addr  = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        repeat (6) step(1, 0, 0, 0);
        repeat (8) step(1, 1, 0, 0);

        repeat (3) step(1, 0, 0, 0);
        step(1, 0, 1, 32'h0000_2003);
        repeat (6) step(1, 1, 0, 0);

        repeat (3) begin
            step(1, 1, 0, 0);
            step(0, 1, 0, 0);
            step(0, 1, 0, 0);
            step(1, 1, 0, 0);
        end

        step(1, 1, 1, 32'hFFFF_FFF8);
        repeat (6) step(1, 1, 0, 0);
        step(1, 0, 1, 32'hFFFF_FFFC);
        repeat (4) step(1, 0, 0, 0);
        repeat (4) step(1, 1, 0, 0);

        step(1, 1, 1, 32'h0000_3000);
        step(1, 1, 1, 32'h0000_4006);
        repeat (5) step(1, 1, 0, 0);

        reset = 1'b1;
        step(1, 1, 1, 32'h0000_5000);
        step(1, 1, 1, 32'h0000_5000);
        reset = 1'b0;
        repeat (5) step(1, 0, 0, 0);

        for (int i = 0; i < 2000; i++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'hFFFF_FFF0 | (ra & 32'hF);
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 31) == 0), ra);
        end

        repeat (6) step(1, 1, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
